bcd_serial_sub_ctrl: RTL and testbench

- Multi-digit BCD subtraction sequencer: computes |A-B| and a sign flag for DIGITS-digit packed BCD operands.
- Time-shares one single-digit BCD subtract-with-borrow slice, one digit per cycle, LSD first.
- If the result is negative, runs a second pass through the same slice to ten's-complement the result into a magnitude.
- Sits between operand registers/keypad logic and the display/result path of the BCD arithmetic unit.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_digit_sub.sv | 24 ++
 rtl/bcd_serial_sub_ctrl.sv | 133 +++++++++++++
 tb/tb_bcd_serial_sub_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the serial BCD subtract sequencer.
// Holds the controller state encoding and digit validity check.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    COMP,
    DONE
  } state_t;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd(
    input logic [BCD_W-1:0] digit
  );
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single BCD digit subtract-with-borrow slice.
// A negative raw difference is folded back into 0..9 with +10.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] i_a,
  input  logic [BCD_W-1:0] i_b,
  input  logic             i_bin,
  output logic [BCD_W-1:0] o_d,
  output logic             o_bout
);

  logic [BCD_W:0] w_raw;

  always_comb begin
    w_raw  = {1'b0, i_a} - {1'b0, i_b}
           - {{BCD_W{1'b0}}, i_bin};
    o_bout = w_raw[BCD_W];
    o_d    = o_bout
           ? w_raw[BCD_W-1:0] + BCD_W'(10)
           : w_raw[BCD_W-1:0];
  end

endmodule

// File: rtl/bcd_serial_sub_ctrl.sv
// Digit-serial |A-B| sequencer sharing one BCD slice, LSD first.
// A negative raw result gets a second ten's-complement pass.
module bcd_serial_sub_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BCD_W*DIGITS-1:0] a,
  input  logic [BCD_W*DIGITS-1:0] b,
  output logic                    ready,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] diff,
  output logic                    neg,
  output logic                    err
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_t                    r_state;
  state_t                    w_nxt;
  logic [IW-1:0]             r_idx;
  logic                      r_borrow;
  logic [BCD_W*DIGITS-1:0]   r_a;
  logic [BCD_W*DIGITS-1:0]   r_b;
  logic [BCD_W*DIGITS-1:0]   r_diff;
  logic                      r_neg;
  logic                      r_err;
  logic                      r_done;

  logic                      w_bad;
  logic                      w_last;
  logic                      w_comp;
  logic [BCD_W-1:0]          w_sa;
  logic [BCD_W-1:0]          w_sb;
  logic [BCD_W-1:0]          w_d;
  logic                      w_bout;

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd(a[i*BCD_W +: BCD_W]) ||
          !is_bcd(b[i*BCD_W +: BCD_W]))
        w_bad = 1'b1;
    end
  end

  // COMP pass feeds 0 - r[idx] through the same slice
  assign w_comp = (r_state == COMP);
  assign w_last = (r_idx == LAST);
  assign w_sa   = w_comp ? '0
                : r_a[r_idx*BCD_W +: BCD_W];
  assign w_sb   = w_comp ? r_diff[r_idx*BCD_W +: BCD_W]
                : r_b[r_idx*BCD_W +: BCD_W];

  bcd_digit_sub u_slice (
    .i_a    (w_sa),
    .i_b    (w_sb),
    .i_bin  (r_borrow),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE, DONE: if (start) w_nxt = SUB;
      SUB: begin
        if (r_err)       w_nxt = DONE;
        else if (w_last) w_nxt = w_bout ? COMP : DONE;
      end
      COMP: if (w_last) w_nxt = DONE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx    <= '0;
      r_borrow <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_neg    <= 1'b0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (w_nxt == DONE) && (r_state != DONE);
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_idx    <= '0;
            r_borrow <= 1'b0;
            r_diff   <= '0;
            r_neg    <= 1'b0;
            r_err    <= w_bad;
          end
        end
        SUB, COMP: begin
          if (!r_err) begin
            r_diff[r_idx*BCD_W +: BCD_W] <= w_d;
            if (w_last) begin
              r_idx    <= '0;
              r_borrow <= 1'b0;
              r_neg    <= w_comp;
            end else begin
              r_idx    <= r_idx + 1'b1;
              r_borrow <= w_bout;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (r_state == IDLE) || (r_state == DONE);
  assign done  = r_done;
  assign diff  = r_diff;
  assign neg   = r_neg;
  assign err   = r_err;

endmodule

// File: tb/tb_bcd_serial_sub_ctrl.sv
// Bench for bcd_serial_sub_ctrl: vector table, corner sequences,
// and random operands against an integer-arithmetic model.
module tb_bcd_serial_sub_ctrl;

  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   a = '0;
  logic [15:0]   b = '0;
  logic          ready;
  logic          done;
  logic [15:0]   diff;
  logic          neg;
  logic          err;

  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  bcd_serial_sub_ctrl #(.DIGITS(D)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .diff  (diff),
    .neg   (neg),
    .err   (err)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] diff;
    logic        neg;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    else
      pass_cnt++;
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--)
      r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    int t = v;
    for (int i = 0; i < D; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic has_bad(input logic [15:0] v);
    for (int i = 0; i < D; i++)
      if (v[i*4 +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // Launch one op; k = edges after accept edge until done seen
  task automatic run_op(input string nm,
                        input logic [15:0] ia,
                        input logic [15:0] ib,
                        input logic [15:0] ed,
                        input logic en,
                        input logic ee,
                        input int el);
    int k;
    int rlow;
    logic [15:0] held;
    @(negedge clk);
    chk({nm, "_rdy0"}, ready, 1'b1);
    a = ia;
    b = ib;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    rlow = ready ? 0 : 1;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
      if (!ready) rlow++;
    end
    chk({nm, "_lat"}, k, el);
    chk({nm, "_rlow"}, rlow, el);
    chk({nm, "_diff"}, diff, ed);
    chk({nm, "_neg"}, neg, en);
    chk({nm, "_err"}, err, ee);
    held = diff;
    @(negedge clk);
    chk({nm, "_pulse"}, done, 1'b0);
    chk({nm, "_hold"}, diff, held);
  endtask

  function automatic void model(input logic [15:0] ia,
                                input logic [15:0] ib,
                                output logic [15:0] ed,
                                output logic en,
                                output logic ee,
                                output int el);
    int d;
    if (has_bad(ia) || has_bad(ib)) begin
      ed = '0; en = 1'b0; ee = 1'b1; el = 1;
    end else begin
      d  = bcd2int(ia) - bcd2int(ib);
      en = d < 0;
      ee = 1'b0;
      ed = int2bcd(en ? -d : d);
      el = en ? 2 * D : D;
    end
  endfunction

  initial begin
    int k;
    logic [15:0] ra, rb, ed;
    logic en, ee;
    int el;

    vecs[0] = '{16'h5432, 16'h1234, 16'h4198, 1'b0, 1'b0, 4};
    vecs[1] = '{16'h1234, 16'h5432, 16'h4198, 1'b1, 1'b0, 8};
    vecs[2] = '{16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 4};
    vecs[3] = '{16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 8};
    vecs[4] = '{16'h7777, 16'h7777, 16'h0000, 1'b0, 1'b0, 4};
    vecs[5] = '{16'h12A4, 16'h0000, 16'h0000, 1'b0, 1'b1, 1};

    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_diff", diff, 16'h0);
    chk("rst_neg", neg, 1'b0);
    chk("rst_err", err, 1'b0);
    reset = 1'b0;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
             vecs[i].diff, vecs[i].neg, vecs[i].err,
             vecs[i].lat);

    // start re-pulsed during a busy op is ignored
    @(negedge clk);
    a = 16'h5432; b = 16'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'h9999; b = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 2;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("busy_lat", k, 4);
    chk("busy_diff", diff, 16'h4198);
    chk("busy_neg", neg, 1'b0);

    // start held high: second op accepted the edge after done
    @(negedge clk);
    a = 16'h0500; b = 16'h0100; start = 1'b1;
    @(negedge clk);
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_lat1", k, 4);
    chk("b2b_diff1", diff, 16'h0400);
    chk("b2b_rdy", ready, 1'b1);
    a = 16'h0100; b = 16'h0500;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_acc", ready, 1'b0);
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_lat2", k, 8);
    chk("b2b_diff2", diff, 16'h0400);
    chk("b2b_neg2", neg, 1'b1);

    // reset at cycle 3 of a negative op
    @(negedge clk);
    a = 16'h1234; b = 16'h5432; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rmid_ready", ready, 1'b1);
    chk("rmid_diff", diff, 16'h0);
    chk("rmid_neg", neg, 1'b0);
    chk("rmid_done", done, 1'b0);
    repeat (10) begin
      @(negedge clk);
      if (done) chk("rmid_nodone", done, 1'b0);
    end
    run_op("after_rst", 16'h0042, 16'h0017,
           16'h0025, 1'b0, 1'b0, 4);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < D; i++) begin
        ra[i*4 +: 4] = 4'($urandom_range(0, 9));
        rb[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0)
        ra[$urandom_range(0, D-1)*4 +: 4] =
          4'($urandom_range(10, 15));
      if (n == 0) rb = ra;
      model(ra, rb, ed, en, ee, el);
      run_op($sformatf("rnd%0d", n), ra, rb, ed, en, ee, el);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
